// File: rtl/ping_pong_pkg.sv
// Shared constants for the Ping-Pong paddle path: ADC sample width,
// default paddle geometry and hysteresis, and the centre position.
package ping_pong_pkg;

    localparam int ADC_W        = 12;
    localparam int AVG_LOG2_DEF = 3;
    localparam int POS_W_DEF    = 10;
    localparam int POS_MAX_DEF  = 440;
    localparam int HYST_DEF     = 4;
    localparam int POS_CENTRE   = POS_MAX_DEF / 2;

    // Centre of the travel range for an arbitrary POS_MAX (integer division).
    function automatic int centre_of(input int pos_max);
        return pos_max / 2;
    endfunction

endpackage

// File: rtl/pos_channel.sv
// One paddle channel: window accumulator (stage A), scale to paddle travel
// (stage B) and hysteresis on the output position (stage C). The window
// count and the stage valids are shared and come from the top level.
module pos_channel
    import ping_pong_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int HYST     = HYST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             last_sample,
    input  logic             a_v,
    input  logic             b_v,
    input  logic             first_win,
    input  logic [ADC_W-1:0] data,
    output logic [POS_W-1:0] pos
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    // avg * (POS_MAX+1) needs ADC_W bits plus the width of POS_MAX+1.
    localparam int MUL_W = ADC_W + POS_W + 1;

    localparam logic [POS_W-1:0] CENTRE_V  = POS_W'(centre_of(POS_MAX));
    localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] HYST_V    = POS_W'(HYST);
    localparam logic [MUL_W-1:0] SCALE_V   = MUL_W'(POS_MAX + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ADC_W-1:0] avg_q, avg_d;
    logic [POS_W-1:0] scl_q, scl_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic [ACC_W-1:0] acc_sum;
    logic [MUL_W-1:0] prod;
    logic [POS_W-1:0] diff;
    logic             take;

    // Stage A: add the new sample; on the last sample of a window latch the
    // truncated mean and restart the accumulator.
    always_comb begin
        acc_sum = acc_q + ACC_W'(data);
        acc_d   = acc_q;
        avg_d   = avg_q;
        if (sample_en) begin
            if (last_sample) begin
                acc_d = '0;
                avg_d = ADC_W'(acc_sum >> AVG_LOG2);
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // Stage B: map 0..4095 onto 0..POS_MAX with a single multiply and shift.
    always_comb begin
        prod  = MUL_W'(avg_q) * SCALE_V;
        scl_d = scl_q;
        if (a_v) begin
            scl_d = POS_W'(prod >> ADC_W);
        end
    end

    // Stage C: move only on a large enough change, but always allow the
    // first window and the two end stops so the paddle can reach the walls.
    always_comb begin
        diff  = (scl_q >= pos_q) ? (scl_q - pos_q) : (pos_q - scl_q);
        take  = first_win || (diff >= HYST_V) ||
                (scl_q == '0) || (scl_q == POS_MAX_V);
        pos_d = pos_q;
        if (b_v && take) begin
            pos_d = scl_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
            scl_q <= '0;
            pos_q <= CENTRE_V;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
            scl_q <= scl_d;
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/paddle_position_filter.sv
// Turns the MAX1379 driver's BUSY/data pair into filtered paddle positions.
// BUSY is synchronised and its falling edge is the sample strobe; a shared
// window counter and valid pipeline drive two identical channel datapaths.
module paddle_position_filter
    import ping_pong_pkg::*;
#(
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int HYST     = HYST_DEF
) (
    input  logic             CLOCK_50MHz,
    input  logic             RESET,
    input  logic             ADC_BUSY,
    input  logic [ADC_W-1:0] ADC_DATA0,
    input  logic [ADC_W-1:0] ADC_DATA1,
    input  logic             FREEZE,
    output logic [POS_W-1:0] POS0,
    output logic [POS_W-1:0] POS1,
    output logic             POS_VALID
);

    localparam logic [AVG_LOG2-1:0] CNT_LAST = AVG_LOG2'((1 << AVG_LOG2) - 1);

    logic                busy_s1_q, busy_s1_d;
    logic                busy_s2_q, busy_s2_d;
    logic                busy_dly_q, busy_dly_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic                a_v_q, a_v_d;
    logic                b_v_q, b_v_d;
    logic                pos_valid_q, pos_valid_d;
    logic                first_win_q, first_win_d;

    logic strobe;
    logic sample_en;
    logic last_sample;

    // BUSY synchroniser, falling-edge strobe and shared window/valid control.
    always_comb begin
        busy_s1_d   = ADC_BUSY;
        busy_s2_d   = busy_s1_q;
        busy_dly_d  = busy_s2_q;

        strobe      = busy_dly_q & ~busy_s2_q;
        sample_en   = strobe & ~FREEZE;
        last_sample = (cnt_q == CNT_LAST);

        cnt_d = cnt_q;
        if (sample_en) begin
            cnt_d = last_sample ? '0 : cnt_q + 1'b1;
        end

        a_v_d       = sample_en & last_sample;
        b_v_d       = a_v_q;
        pos_valid_d = b_v_q;
        first_win_d = first_win_q & ~b_v_q;
    end

    // Control registers; synchroniser resets high so an idle-high BUSY
    // produces no edge when reset releases.
    always_ff @(posedge CLOCK_50MHz) begin
        if (RESET) begin
            busy_s1_q   <= 1'b1;
            busy_s2_q   <= 1'b1;
            busy_dly_q  <= 1'b1;
            cnt_q       <= '0;
            a_v_q       <= 1'b0;
            b_v_q       <= 1'b0;
            pos_valid_q <= 1'b0;
            first_win_q <= 1'b1;
        end else begin
            busy_s1_q   <= busy_s1_d;
            busy_s2_q   <= busy_s2_d;
            busy_dly_q  <= busy_dly_d;
            cnt_q       <= cnt_d;
            a_v_q       <= a_v_d;
            b_v_q       <= b_v_d;
            pos_valid_q <= pos_valid_d;
            first_win_q <= first_win_d;
        end
    end

    pos_channel #(
        .AVG_LOG2 (AVG_LOG2),
        .POS_W    (POS_W),
        .POS_MAX  (POS_MAX),
        .HYST     (HYST)
    ) u_ch0 (
        .clk         (CLOCK_50MHz),
        .rst         (RESET),
        .sample_en   (sample_en),
        .last_sample (last_sample),
        .a_v         (a_v_q),
        .b_v         (b_v_q),
        .first_win   (first_win_q),
        .data        (ADC_DATA0),
        .pos         (POS0)
    );

    pos_channel #(
        .AVG_LOG2 (AVG_LOG2),
        .POS_W    (POS_W),
        .POS_MAX  (POS_MAX),
        .HYST     (HYST)
    ) u_ch1 (
        .clk         (CLOCK_50MHz),
        .rst         (RESET),
        .sample_en   (sample_en),
        .last_sample (last_sample),
        .a_v         (a_v_q),
        .b_v         (b_v_q),
        .first_win   (first_win_q),
        .data        (ADC_DATA1),
        .pos         (POS1)
    );

    assign POS_VALID = pos_valid_q;

endmodule

// File: tb/tb_paddle_position_filter.sv
// Directed bench for paddle_position_filter. The driver pushes the expected
// positions and arrival cycle of each completed window into a queue; the
// monitor pops and compares whenever POS_VALID is seen.
module tb_paddle_position_filter;
    import ping_pong_pkg::*;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        busy   = 1'b1;
    logic        freeze = 1'b0;
    logic [11:0] d0     = '0;
    logic [11:0] d1     = '0;
    logic [9:0]  pos0;
    logic [9:0]  pos1;
    logic        pos_valid;

    paddle_position_filter dut (
        .CLOCK_50MHz (clk),
        .RESET       (rst),
        .ADC_BUSY    (busy),
        .ADC_DATA0   (d0),
        .ADC_DATA1   (d1),
        .FREEZE      (freeze),
        .POS0        (pos0),
        .POS1        (pos1),
        .POS_VALID   (pos_valid)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int p0;
        int p1;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   last_fall = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One ADC conversion: BUSY high, then a falling edge with data held.
    task automatic sample(input logic [11:0] a, input logic [11:0] b,
                          input logic frz, input int hold);
        busy = 1'b1;
        tick(4);
        d0     = a;
        d1     = b;
        freeze = frz;
        busy   = 1'b0;
        last_fall = int'(cyc);
        tick(hold);
    endtask

    // Fall at cycle k: synced edge k+2 gives the strobe, POS_VALID at k+5.
    task automatic push(input int e0, input int e1);
        exp_t e;
        e.p0 = e0;
        e.p1 = e1;
        e.at = last_fall + 5;
        sbq.push_back(e);
    endtask

    task automatic window(input logic [11:0] a, input logic [11:0] b,
                          input int e0, input int e1);
        for (int i = 0; i < 8; i++) sample(a, b, 1'b0, 4);
        push(e0, e1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sbq.size() != 0 && t < 50) begin
            tick(1);
            t++;
        end
        check(name, sbq.size(), 0);
    endtask

    // Monitor: compare every POS_VALID against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && pos_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got POS_VALID=1 with no window pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pos0", int'(pos0), e.p0);
                check("pos1", int'(pos1), e.p1);
                check("valid_cycle", int'(cyc), e.at);
            end
        end
    end

    initial begin
        tick(3);
        check("reset_pos0", int'(pos0), 220);
        check("reset_pos1", int'(pos1), 220);
        check("reset_valid", int'(pos_valid), 0);
        rst = 1'b0;
        tick(3);

        // Endpoints on the first window.
        window(12'hFFF, 12'h000, 440, 0);
        drain("drain_endpoints");

        // Centre, sub-hysteresis hold, then a move.
        window(12'd2048, 12'd2048, 220, 220);
        window(12'd2080, 12'd2080, 220, 220);
        window(12'd2100, 12'd2100, 226, 226);
        drain("drain_hyst");

        // Ramp 100..107 on channel 0: mean 103 -> 11.
        for (int i = 0; i < 8; i++) sample(12'(100 + i), 12'd2100, 1'b0, 4);
        push(11, 226);
        drain("drain_ramp");

        // Frozen strobes in mid-window must not count or accumulate.
        for (int i = 0; i < 2; i++) sample(12'd4000, 12'd2048, 1'b0, 4);
        for (int i = 0; i < 4; i++) sample(12'd0, 12'd4095, 1'b1, 4);
        for (int i = 0; i < 6; i++) sample(12'd4000, 12'd2048, 1'b0, 4);
        push(430, 220);
        // Change of exactly HYST moves channel 1; channel 0 unchanged.
        window(12'd4000, 12'd2081, 430, 224);
        drain("drain_freeze");

        // Reset in the middle of a window.
        for (int i = 0; i < 5; i++) sample(12'd4095, 12'd4095, 1'b0, 4);
        busy = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        check("midreset_pos0", int'(pos0), 220);
        check("midreset_pos1", int'(pos1), 220);
        check("midreset_valid", int'(pos_valid), 0);
        rst = 1'b0;
        tick(3);
        // First window after reset bypasses hysteresis (221 is within 4 of 220).
        window(12'd2060, 12'd3000, 221, 322);
        window(12'd19, 12'd4069, 2, 438);
        drain("drain_after_reset");

        // BUSY low for 1000 cycles, then high for 1000: one sample only.
        sample(12'd0, 12'd4095, 1'b0, 1000);
        busy = 1'b1;
        tick(1000);
        check("stuck_pos0", int'(pos0), 2);
        check("stuck_pos1", int'(pos1), 438);
        // Remaining 7 samples; end stops bypass the sub-HYST change.
        for (int i = 0; i < 7; i++) sample(12'd0, 12'd4095, 1'b0, 4);
        push(0, 440);
        drain("drain_stuck");

        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
